muldiv_unit: RTL

Parametrised multi-cycle multiply/divide engine that owns the architectural HI/LO registers. It replaces the combinational HI/LO handling in the datapath ALU. It sits beside the ALU in the execute stage and is driven by the same 6-bit function code. The pipeline stalls on w_busy. MFHI/MFLO read the registered HI/LO outputs directly.

---
 rtl/muldiv_unit_pkg.sv | 22 ++
 rtl/muldiv_unit_divstep.sv | 19 +
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared function codes and engine state encoding for the multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
    localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
    localparam logic [5:0] SPECIAL_MULT  = 6'h18;
    localparam logic [5:0] SPECIAL_MULTU = 6'h19;
    localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
    localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_e;

    function automatic logic is_signed_op(input logic [5:0] op);
        return (op == SPECIAL_MULT) || (op == SPECIAL_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_divstep.sv
// Combinational restoring-division step: shift in one dividend bit, trial-subtract the divisor.
module muldiv_unit_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, next_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // The true difference is below the divisor, so modulo-2^WIDTH subtraction is exact.
    assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine owning HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier in place of the shift-add loop.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_start,
    input  logic [5:0]       w_op_code_6,
    input  logic [WIDTH-1:0] w_input1_x,
    input  logic [WIDTH-1:0] w_input2_x,
    output logic             w_busy,
    output logic             w_done,
    output logic             w_div_zero,
    output logic [WIDTH-1:0] w_hi_x,
    output logic [WIDTH-1:0] w_lo_x
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [W2-1:0]    ONE_W2 = W2'(1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             is_mul_q, is_mul_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] ds_rem;
    logic             ds_q;
    logic [W2-1:0]    acc_neg;
    logic [WIDTH-1:0] hi_neg, lo_neg;
    logic [W2-1:0]    mul_next;

    assign a_neg = is_signed_op(w_op_code_6) & w_input1_x[WIDTH-1];
    assign b_neg = is_signed_op(w_op_code_6) & w_input2_x[WIDTH-1];
    assign a_mag = a_neg ? (~w_input1_x + ONE_W) : w_input1_x;
    assign b_mag = b_neg ? (~w_input2_x + ONE_W) : w_input2_x;

    assign acc_neg = ~acc_q + ONE_W2;
    assign hi_neg  = ~acc_q[W2-1:WIDTH] + ONE_W;
    assign lo_neg  = ~acc_q[WIDTH-1:0] + ONE_W;

    // Division keeps the partial remainder in the upper half and shifts quotient bits into the lower half.
    muldiv_unit_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in   (acc_q[W2-1:WIDTH]),
        .divisor  (b_q),
        .next_bit (acc_q[WIDTH-1]),
        .rem_out  (ds_rem),
        .q_bit    (ds_q)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign mul_next = W2'(acc_q[WIDTH-1:0]) * W2'(b_q);
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        is_mul_d  = is_mul_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (w_start) begin
                    case (w_op_code_6)
                        SPECIAL_MTHI: begin
                            hi_d   = w_input1_x;
                            done_d = 1'b1;
                        end
                        SPECIAL_MTLO: begin
                            lo_d   = w_input1_x;
                            done_d = 1'b1;
                        end
                        SPECIAL_MULT, SPECIAL_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            b_d       = a_mag;
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = 1'b0;
                            is_mul_d  = 1'b1;
                            cnt_d     = '0;
                            dz_d      = 1'b0;
                            state_d   = MD_MUL;
                        end
                        SPECIAL_DIV, SPECIAL_DIVU: begin
                            is_mul_d = 1'b0;
                            cnt_d    = '0;
                            if (w_input2_x == '0) begin
                                acc_d     = {w_input1_x, {WIDTH{1'b1}}};
                                neg_d     = 1'b0;
                                rem_neg_d = 1'b0;
                                dz_d      = 1'b1;
                                state_d   = MD_FIX;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, a_mag};
                                b_d       = b_mag;
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                                dz_d      = 1'b0;
                                state_d   = MD_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                acc_d = mul_next;
`ifdef MULDIV_FAST_MUL_EN
                state_d = MD_FIX;
`else
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = MD_FIX;
`endif
            end
            MD_DIV: begin
                acc_d = {ds_rem, acc_q[WIDTH-2:0], ds_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (is_mul_q) begin
                    hi_d = neg_q ? acc_neg[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
                    lo_d = neg_q ? acc_neg[WIDTH-1:0]  : acc_q[WIDTH-1:0];
                end else begin
                    hi_d = rem_neg_q ? hi_neg : acc_q[W2-1:WIDTH];
                    lo_d = neg_q     ? lo_neg : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_mul_q  <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            is_mul_q  <= is_mul_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign w_busy     = (state_q != MD_IDLE);
    assign w_done     = done_q;
    assign w_div_zero = dz_q;
    assign w_hi_x     = hi_q;
    assign w_lo_x     = lo_q;

endmodule
